// File: rtl/dm_responder.sv
// Wait-state data memory responder: one request in flight, fixed access latency, byte-enable writes.
// Optional write logging is compiled in when DM_WRITE_LOG_EN is defined.
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          mem_we;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    assign acc_err = addr_err(addr_q);
    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem_q[idx];
    assign wr_word = merge_be(rd_word, wdata_q, be_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        accept      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The access itself happens on the edge that leaves WAIT.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? 32'h0 : rd_word;
                    mem_we      = we_q && !acc_err;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request fields are captured only on accept, so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            be_q    <= req_be;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (accept) pc_q <= req_pc;
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else if (mem_we) begin
            mem_q[idx] <= wr_word;
`ifdef DM_WRITE_LOG_EN
            $display("[%0t] @%08h: *%08h <= %08h", $time, pc_q, {addr_q[31:2], 2'b00}, wr_word);
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder with a word-array reference model of the memory.
module tb_dm_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dm_responder #(.WAIT_CYCLES(WAIT_CYCLES), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mdl [DEPTH_WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH_WORDS; i++) mdl[i] = 32'h0;
    endtask

    function automatic logic mdl_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 32'(DEPTH_WORDS));
    endfunction

    // Called just after a rising edge; reset is released well before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        #2;
        reset = 1'b0;
        mdl_clear();
    endtask

    // abort: 0 = complete, 1 = reset while waiting, 2 = reset while responding
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        input int hold, input int abort);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] merged;
        logic [31:0] held_rd;
        logic        held_err;
        int          edges;
        chk("ready_idle", {31'b0, req_ready}, 32'h1);
        exp_err = mdl_err(addr);
        exp_rd  = (exp_err || we) ? 32'h0 : mdl[addr / 4];
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
        step();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_be    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_pc    = $urandom;
        chk("ready_busy", {31'b0, req_ready}, 32'h0);
        if (abort == 1) begin
            do_reset();
            return;
        end
        edges = 0;
        while (!rsp_valid && edges < 64) begin
            step();
            edges++;
            if (!rsp_valid) chk("ready_wait", {31'b0, req_ready}, 32'h0);
        end
        chk("latency", 32'(edges), 32'(WAIT_CYCLES + 1));
        chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (we && !exp_err) begin
            merged = mdl[addr / 4];
            for (int b = 0; b < 4; b++)
                if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
            mdl[addr / 4] = merged;
        end
        if (abort == 2) begin
            do_reset();
            return;
        end
        held_rd  = rsp_rdata;
        held_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", {31'b0, rsp_valid}, 32'h1);
            chk("hold_rdata", rsp_rdata, held_rd);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, held_err});
            chk("hold_ready", {31'b0, req_ready}, 32'h0);
        end
        // A request offered during the handshake cycle must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0;
        req_be    = 4'hF;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("done_valid", {31'b0, rsp_valid}, 32'h0);
        chk("done_ready", {31'b0, req_ready}, 32'h1);
        chk("idle_rdata", rsp_rdata, held_rd);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_pc    = 32'h0;
        rsp_ready = 1'b0;
        mdl_clear();
        #2;
        chk("init_valid", {31'b0, rsp_valid}, 32'h0);
        chk("init_rdata", rsp_rdata, 32'h0);
        chk("init_err", {31'b0, rsp_err}, 32'h0);
        chk("init_ready", {31'b0, req_ready}, 32'h1);
        step();
        step();
        reset = 1'b0;

        xact(1'b1, 4'hF, 32'h10, 32'h12345678, 32'h100, 0, 0);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 32'h104, 0, 0);
        chk("basic_read", rsp_rdata, 32'h12345678);
        xact(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, 32'h108, 1, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 32'h10C, 0, 0);
        chk("be_merge", rsp_rdata, 32'h12BB56DD);
        xact(1'b0, 4'hF, 32'h12, 32'h0, 32'h110, 0, 0);
        chk("misalign_err", {31'b0, rsp_err}, 32'h1);
        xact(1'b1, 4'hF, 32'(4 * DEPTH_WORDS), 32'hDEADBEEF, 32'h114, 0, 0);
        chk("range_err", {31'b0, rsp_err}, 32'h1);
        xact(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h118, 0, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 32'h11C, 5, 0);
        chk("unchanged", rsp_rdata, 32'h12BB56DD);
        xact(1'b1, 4'hF, 32'(4 * DEPTH_WORDS - 4), 32'hCAFEF00D, 32'h120, 0, 0);
        xact(1'b0, 4'hF, 32'(4 * DEPTH_WORDS - 4), 32'h0, 32'h124, 2, 0);
        chk("last_word", rsp_rdata, 32'hCAFEF00D);

        xact(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 32'h200, 0, 1);
        xact(1'b0, 4'hF, 32'h20, 32'h0, 32'h204, 0, 0);
        chk("abort_write", rsp_rdata, 32'h0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 32'h208, 0, 0);
        chk("reset_clears", rsp_rdata, 32'h0);
        xact(1'b1, 4'hF, 32'h30, 32'h55AA55AA, 32'h20C, 0, 0);
        xact(1'b0, 4'hF, 32'h30, 32'h0, 32'h210, 0, 2);
        chk("resp_drop", {31'b0, rsp_valid}, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom % 16);
            if (r == 0)      a = ($urandom % 128) | 32'h1 + ($urandom % 2);
            else if (r == 1) a = 32'((DEPTH_WORDS + int'($urandom % 64)) * 4);
            else if (r == 2) a = 32'(4 * DEPTH_WORDS - 4);
            else             a = ($urandom % 32) * 4;
            xact(1'($urandom), 4'($urandom), a, $urandom, $urandom, int'($urandom % 4), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
